// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control FSM for an RV32I datapath:
//   FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH / IDLE.
//   Drives the IR load, the PC commit, the gated register-file write and the
//   data-memory strobes. It also watches memory handshakes for a timeout,
//   honours a deferred halt request and counts retired instructions.
//
// Parameters
//   TIMEOUT_CYCLES : cycles a FETCH/MEMORY handshake may wait before ERROR
//                    (0 disables the timeout)
//   RET_WIDTH      : width of the retired-instruction counter (wraps)
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   run           : level, leaves IDLE while high
//   halt_req      : finish current instruction, then return to IDLE
//   write/store/load/illegal : decoded instruction flags
//   imem_req/imem_valid      : instruction fetch handshake
//   ir_load       : latch instruction register
//   dmem_req/dmem_we/dmem_valid : data memory handshake
//   reg_write_en  : register-file write enable
//   pc_enable     : commit next PC (one pulse per completed instruction)
//   error         : sticky error (timeout or illegal opcode)
//   state         : current state encoding
//   retired       : retired-instruction count
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned RET_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic                 write,
  input  logic                 store,
  input  logic                 load,
  input  logic                 illegal,
  output logic                 imem_req,
  input  logic                 imem_valid,
  output logic                 ir_load,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_valid,
  output logic                 reg_write_en,
  output logic                 pc_enable,
  output logic                 error,
  output logic [2:0]           state,
  output logic [RET_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  // Wait counter only needs to reach TIMEOUT_CYCLES-1: the limit cycle is
  // the one on which the counter already holds that value.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_wait_cnt;
  logic                   r_halt;
  logic [RET_WIDTH-1:0]   r_retired;

  logic                   w_halt_pend;
  logic                   w_limit;
  logic                   w_waiting;
  state_t                 w_commit_next;

  // A halt request seen on the commit cycle itself also counts.
  assign w_halt_pend   = r_halt | halt_req;
  assign w_commit_next = w_halt_pend ? S_IDLE : S_FETCH;

  assign w_limit = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == LIMIT);

  assign w_waiting = ((r_state == S_FETCH)  && !imem_valid) ||
                     ((r_state == S_MEMORY) && !dmem_valid);

  // Next-state and strobe decode
  always_comb begin
    w_next       = r_state;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write_en = 1'b0;
    pc_enable    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (run && !halt_req) begin
          w_next = S_FETCH;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_load = 1'b1;
          w_next  = S_DECODE;
        end else if (w_limit) begin
          w_next = S_ERROR;
        end
      end

      S_DECODE: begin
        w_next = illegal ? S_ERROR : S_EXECUTE;
      end

      S_EXECUTE: begin
        if (load || store) begin
          w_next = S_MEMORY;
        end else if (write) begin
          w_next = S_WRITEBACK;
        end else begin
          pc_enable = 1'b1;
          w_next    = w_commit_next;
        end
      end

      S_MEMORY: begin
        dmem_req = 1'b1;
        // load wins when both flags are set
        dmem_we  = store && !load;
        if (dmem_valid) begin
          if (load) begin
            w_next = S_WRITEBACK;
          end else begin
            pc_enable = 1'b1;
            w_next    = w_commit_next;
          end
        end else if (w_limit) begin
          w_next = S_ERROR;
        end
      end

      S_WRITEBACK: begin
        reg_write_en = 1'b1;
        pc_enable    = 1'b1;
        w_next       = w_commit_next;
      end

      S_ERROR: begin
        w_next = S_ERROR;
      end

      default: begin
        w_next = S_ERROR;
      end
    endcase
  end

  // State, wait counter, halt latch, retired counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_halt     <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_waiting && (TIMEOUT_CYCLES != 0)) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end

      if (w_next == S_IDLE) begin
        r_halt <= 1'b0;
      end else if ((r_state != S_IDLE) && halt_req) begin
        r_halt <= 1'b1;
      end

      if (pc_enable) begin
        r_retired <= r_retired + RET_WIDTH'(1);
      end
    end
  end

  assign error   = (r_state == S_ERROR);
  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
//   Directed bench for core_sequencer (TIMEOUT_CYCLES=4, RET_WIDTH=2).
//   Inputs are driven just after the falling edge; outputs are sampled 1ns
//   later, well before the next rising edge.
//   Strobe vector order: {imem_req, ir_load, dmem_req, dmem_we,
//                         reg_write_en, pc_enable, error}
// -----------------------------------------------------------------------------
module tb_core_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, halt_req, write, store, load, illegal;
  logic       imem_valid, dmem_valid;
  logic       imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_enable, error;
  logic [2:0] state;
  logic [1:0] retired;
  logic [6:0] strb;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam logic [6:0] SB_NONE  = 7'b0000000;
  localparam logic [6:0] SB_IMREQ = 7'b1000000;
  localparam logic [6:0] SB_FETCH = 7'b1100000;
  localparam logic [6:0] SB_MRD   = 7'b0010000;
  localparam logic [6:0] SB_MWR   = 7'b0011010;
  localparam logic [6:0] SB_WB    = 7'b0000110;
  localparam logic [6:0] SB_PC    = 7'b0000010;
  localparam logic [6:0] SB_ERR   = 7'b0000001;

  always #5 clk = ~clk;

  core_sequencer #(
    .TIMEOUT_CYCLES(4),
    .RET_WIDTH     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .halt_req    (halt_req),
    .write       (write),
    .store       (store),
    .load        (load),
    .illegal     (illegal),
    .imem_req    (imem_req),
    .imem_valid  (imem_valid),
    .ir_load     (ir_load),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_valid  (dmem_valid),
    .reg_write_en(reg_write_en),
    .pc_enable   (pc_enable),
    .error       (error),
    .state       (state),
    .retired     (retired)
  );

  assign strb = {imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_enable, error};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [6:0] sb);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".strb"},  32'(strb),  32'(sb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; halt_req = 1'b0; write = 1'b0; store = 1'b0;
    load = 1'b0; illegal = 1'b0; imem_valid = 1'b0; dmem_valid = 1'b0;

    // Reset state
    @(negedge clk); #1;
    expect_cyc("rst", 3'd0, SB_NONE);
    check("rst.ret", 32'(retired), 32'd0);

    // Zero-wait ALU op with rd write
    @(negedge clk); rst = 1'b0; run = 1'b1; write = 1'b1; #1;
    expect_cyc("alu.idle", 3'd0, SB_NONE);
    @(negedge clk); imem_valid = 1'b1; #1;
    expect_cyc("alu.fetch", 3'd1, SB_FETCH);
    @(negedge clk); imem_valid = 1'b0; #1;
    expect_cyc("alu.dec", 3'd2, SB_NONE);
    @(negedge clk); #1;
    expect_cyc("alu.exe", 3'd3, SB_NONE);
    @(negedge clk); #1;
    expect_cyc("alu.wb", 3'd5, SB_WB);
    check("alu.wb.ret", 32'(retired), 32'd0);
    @(negedge clk); #1;
    expect_cyc("alu.next", 3'd1, SB_IMREQ);
    check("alu.ret", 32'(retired), 32'd1);

    // Load with dmem_valid on the 3rd MEMORY cycle
    load = 1'b1; imem_valid = 1'b1; #1;
    expect_cyc("ld.fetch", 3'd1, SB_FETCH);
    @(negedge clk); imem_valid = 1'b0; #1;
    expect_cyc("ld.dec", 3'd2, SB_NONE);
    @(negedge clk); #1;
    expect_cyc("ld.exe", 3'd3, SB_NONE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); dmem_valid = (i == 2); #1;
      expect_cyc("ld.mem", 3'd4, SB_MRD);
    end
    @(negedge clk); dmem_valid = 1'b0; #1;
    expect_cyc("ld.wb", 3'd5, SB_WB);
    @(negedge clk); #1;
    expect_cyc("ld.next", 3'd1, SB_IMREQ);
    check("ld.ret", 32'(retired), 32'd2);

    // Store, dmem_valid on the first MEMORY cycle
    load = 1'b0; write = 1'b0; store = 1'b1; imem_valid = 1'b1; #1;
    expect_cyc("st.fetch", 3'd1, SB_FETCH);
    @(negedge clk); imem_valid = 1'b0; #1;
    expect_cyc("st.dec", 3'd2, SB_NONE);
    @(negedge clk); #1;
    expect_cyc("st.exe", 3'd3, SB_NONE);
    @(negedge clk); dmem_valid = 1'b1; #1;
    expect_cyc("st.mem", 3'd4, SB_MWR);
    @(negedge clk); dmem_valid = 1'b0; store = 1'b0; #1;
    expect_cyc("st.next", 3'd1, SB_IMREQ);
    check("st.ret", 32'(retired), 32'd3);

    // Fetch timeout: the FETCH cycle above is the first of four
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      expect_cyc("to.fetch", 3'd1, SB_IMREQ);
    end
    @(negedge clk); imem_valid = 1'b1; dmem_valid = 1'b1; #1;
    expect_cyc("to.err", 3'd6, SB_ERR);
    @(negedge clk); #1;
    expect_cyc("to.sticky", 3'd6, SB_ERR);
    imem_valid = 1'b0; dmem_valid = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    expect_cyc("to.rst", 3'd0, SB_NONE);
    check("to.rst.ret", 32'(retired), 32'd0);

    // imem_valid arriving on the limit cycle wins; then a no-write ALU op
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      expect_cyc("tv.wait", 3'd1, SB_IMREQ);
    end
    @(negedge clk); imem_valid = 1'b1; #1;
    expect_cyc("tv.f4", 3'd1, SB_FETCH);
    @(negedge clk); imem_valid = 1'b0; #1;
    expect_cyc("tv.dec", 3'd2, SB_NONE);
    @(negedge clk); #1;
    expect_cyc("tv.exe", 3'd3, SB_PC);
    @(negedge clk); #1;
    expect_cyc("tv.next", 3'd1, SB_IMREQ);
    check("tv.ret", 32'(retired), 32'd1);

    // Halt pulsed in EXECUTE: commit, then IDLE; halt_req held in IDLE stays
    write = 1'b1; imem_valid = 1'b1; #1;
    expect_cyc("h.fetch", 3'd1, SB_FETCH);
    @(negedge clk); imem_valid = 1'b0; #1;
    expect_cyc("h.dec", 3'd2, SB_NONE);
    @(negedge clk); halt_req = 1'b1; #1;
    expect_cyc("h.exe", 3'd3, SB_NONE);
    @(negedge clk); halt_req = 1'b0; #1;
    expect_cyc("h.wb", 3'd5, SB_WB);
    @(negedge clk); halt_req = 1'b1; #1;
    expect_cyc("h.idle", 3'd0, SB_NONE);
    check("h.ret", 32'(retired), 32'd2);
    @(negedge clk); #1;
    expect_cyc("h.hold", 3'd0, SB_NONE);
    @(negedge clk); halt_req = 1'b0; write = 1'b0; #1;
    expect_cyc("h.hold2", 3'd0, SB_NONE);

    // Illegal opcode in DECODE
    @(negedge clk); imem_valid = 1'b1; #1;
    expect_cyc("il.fetch", 3'd1, SB_FETCH);
    @(negedge clk); imem_valid = 1'b0; illegal = 1'b1; #1;
    expect_cyc("il.dec", 3'd2, SB_NONE);
    @(negedge clk); #1;
    expect_cyc("il.err", 3'd6, SB_ERR);
    check("il.ret", 32'(retired), 32'd2);
    illegal = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    expect_cyc("il.rst", 3'd0, SB_NONE);

    // Load+store together behaves as load; reset mid-MEMORY aborts
    rst = 1'b0; load = 1'b1; store = 1'b1;
    @(negedge clk); imem_valid = 1'b1; #1;
    expect_cyc("r.fetch", 3'd1, SB_FETCH);
    @(negedge clk); imem_valid = 1'b0; #1;
    expect_cyc("r.dec", 3'd2, SB_NONE);
    @(negedge clk); #1;
    expect_cyc("r.exe", 3'd3, SB_NONE);
    @(negedge clk); #1;
    expect_cyc("r.mem", 3'd4, SB_MRD);
    rst = 1'b1;
    @(negedge clk); #1;
    expect_cyc("r.rst", 3'd0, SB_NONE);
    check("r.ret", 32'(retired), 32'd0);

    // Four commits wrap the 2-bit retired counter
    rst = 1'b0; load = 1'b0; store = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); imem_valid = 1'b1; #1;
      expect_cyc("w.fetch", 3'd1, SB_FETCH);
      check("w.ret", 32'(retired), 32'(i));
      @(negedge clk); imem_valid = 1'b0; #1;
      expect_cyc("w.dec", 3'd2, SB_NONE);
      @(negedge clk); #1;
      expect_cyc("w.exe", 3'd3, SB_PC);
    end
    @(negedge clk); #1;
    expect_cyc("w.next", 3'd1, SB_IMREQ);
    check("w.wrap", 32'(retired), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle FSM sequencing the RV32I datapath: fetch, decode, execute, memory access, writeback. Consumes the decoded write/store/load/illegal flags and handshakes with instruction and data memory. Produces the instruction-register load, PC update enable, gated register-file write enable and data-memory strobes. Includes a memory-wait timeout, a halt request and a retired-instruction counter.

Parameters:
TIMEOUT_CYCLES, 16, max wait cycles on a memory handshake before ERROR; 0 disables timeout
RET_WIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
run  in  1  level; leaves IDLE when high
halt_req  in  1  finish current instruction, then go to IDLE
write  in  1  decoded: instruction writes rd
store  in  1  decoded: store instruction
load  in  1  decoded: load instruction
illegal  in  1  decoded: unsupported opcode
imem_req  out  1  instruction fetch request
imem_valid  in  1  instruction data valid this cycle
ir_load  out  1  latch instruction register
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write strobe
dmem_valid  in  1  data access complete this cycle
reg_write_en  out  1  register-file write enable
pc_enable  out  1  commit next PC
error  out  1  sticky timeout/illegal flag
state  out  3  current state encoding
retired  out  RET_WIDTH  instructions retired

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=6.
- Reset: state=IDLE; all outputs 0; retired=0; error=0; wait counter=0. Reset mid-operation aborts the instruction with no commit.
- IDLE: if run=1 and halt_req=0, go to FETCH next cycle.
- FETCH: imem_req=1 held until imem_valid. If imem_valid=1 (including the first cycle), ir_load=1 that same cycle and next state is DECODE.
- DECODE: one cycle so the decoded inputs settle from the IR. If illegal=1, go to ERROR; otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - load or store -> MEMORY.
  - Else write -> WRITEBACK.
  - Else pc_enable=1 this cycle and go to FETCH (or IDLE if halt pending).
- MEMORY: dmem_req=1 and dmem_we=store, held until dmem_valid.
  - On dmem_valid with load -> WRITEBACK.
  - On dmem_valid with store -> pc_enable=1 and go to FETCH or IDLE.
  - If load and store are both set, treat as load with dmem_we=0.
- WRITEBACK: reg_write_en=1 and pc_enable=1 for exactly one cycle, then FETCH or IDLE.
- pc_enable pulses exactly once per completed instruction. On that same cycle, retired increments and wraps at 2^RET_WIDTH.
- halt_req: sampled and latched in any non-IDLE state. It takes effect at the next commit: go to IDLE instead of FETCH. Latch clears on entering IDLE. halt_req=1 in IDLE holds IDLE.
- Timeout counter: counts cycles spent in FETCH or MEMORY without valid; resets on every state change.
  - When the count reaches TIMEOUT_CYCLES with no valid, go to ERROR next cycle.
  - Valid on the same cycle the limit is reached wins; no error.
- ERROR: error=1; all strobes 0; remains until rst.
- Strobes are combinational from state and the decoded inputs. dmem_valid/imem_valid outside their states are ignored.

Test Plan:
- Zero-wait ALU op: rst then run=1, imem_valid=1 in the first FETCH cycle, write=1, no load/store -> states 1,2,3,5,1; reg_write_en and pc_enable both high in the WRITEBACK cycle; retired=1.
- Load with 3-cycle dmem wait: load=1, write=1, dmem_valid on the 3rd MEMORY cycle -> dmem_req high for 3 cycles, dmem_we=0, then WRITEBACK; retired increments once.
- Store: store=1, dmem_valid on the first MEMORY cycle -> dmem_we=1 for one cycle, pc_enable on the same cycle, reg_write_en never high, next state FETCH.
- Timeout: TIMEOUT_CYCLES=4, imem_valid held 0 -> ERROR after 4 FETCH cycles, error=1 sticky. Repeat with imem_valid arriving on the 4th cycle -> DECODE, error=0.
- Halt and illegal: halt_req pulsed during EXECUTE -> commit then IDLE, retired +1, no further imem_req. Separately, illegal=1 in DECODE -> ERROR, no pc_enable.
- Reset mid-MEMORY plus counter wrap: rst asserted in MEMORY -> IDLE next cycle, all outputs 0. With RET_WIDTH=2, 4 commits -> retired returns to 0.
